// File: rtl/pixel_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_wr_arbiter_if
//  Description : Requester handshakes, clear control and RAM write-port
//                signals for the lower half-matrix pixel write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pixel_wr_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    // Requester A
    logic              a_valid;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;
    // Requester B
    logic              b_valid;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;
    // Clear engine control / status
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;
    // RAM write port
    logic              we_lower;
    logic [ADDR_W-1:0] wraddr_col_lower;
    logic [DATA_W-1:0] din_col_lower;

    // Requesters, clear controller and RAM side
    modport master (
        output a_valid, a_addr, a_data,
        input  a_ready,
        output b_valid, b_addr, b_data,
        input  b_ready,
        output clr_start,
        input  clr_busy, clr_done,
        input  we_lower, wraddr_col_lower, din_col_lower
    );

    // Arbiter side
    modport slave (
        input  a_valid, a_addr, a_data,
        output a_ready,
        input  b_valid, b_addr, b_data,
        output b_ready,
        input  clr_start,
        output clr_busy, clr_done,
        output we_lower, wraddr_col_lower, din_col_lower
    );
endinterface
`default_nettype wire

// File: rtl/pixel_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_wr_arbiter
//  Description : Shares the lower pixel RAM write port between two requesters
//                with round-robin arbitration; a clear engine sweeping every
//                word to a fill value takes priority over both.
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_wr_arbiter #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 1024,
    parameter logic [DATA_W-1:0] CLR_VALUE = 32'h0000_0000
) (
    input wire logic           clk,
    input wire logic           rst,     // synchronous, active-low
    pixel_wr_arbiter_if.slave  bus
);

    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic c_GRANT_A = 1'b0;
    localparam logic c_GRANT_B = 1'b1;

    // Address of the final word of a sweep; the counter never wraps past it.
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic              r_last_grant;

    logic w_in_arb;
    logic w_a_ready;
    logic w_b_ready;

    assign w_in_arb = (r_state == ST_ARB);

    // Round-robin grant: the requester that did not win last time wins a tie.
    // A pending clear start blocks both so that no request slips in ahead of it.
    always_comb begin
        w_a_ready = w_in_arb & bus.a_valid & ~bus.clr_start &
                    (~bus.b_valid | (r_last_grant == c_GRANT_B));
        w_b_ready = w_in_arb & bus.b_valid & ~bus.clr_start &
                    (~bus.a_valid | (r_last_grant == c_GRANT_A));
    end

    assign bus.a_ready = w_a_ready;
    assign bus.b_ready = w_b_ready;

    // Arbitration / clear sweep state machine and registered RAM write port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state              <= ST_ARB;
            r_cnt                <= '0;
            r_last_grant         <= c_GRANT_B;
            bus.we_lower         <= 1'b0;
            bus.wraddr_col_lower <= '0;
            bus.din_col_lower    <= '0;
            bus.clr_busy         <= 1'b0;
            bus.clr_done         <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    bus.clr_done <= 1'b0;
                    if (bus.clr_start) begin
                        r_state      <= ST_CLEAR;
                        r_cnt        <= '0;
                        bus.clr_busy <= 1'b1;
                        bus.we_lower <= 1'b0;
                    end else if (w_a_ready) begin
                        bus.we_lower         <= 1'b1;
                        bus.wraddr_col_lower <= bus.a_addr;
                        bus.din_col_lower    <= bus.a_data;
                        r_last_grant         <= c_GRANT_A;
                    end else if (w_b_ready) begin
                        bus.we_lower         <= 1'b1;
                        bus.wraddr_col_lower <= bus.b_addr;
                        bus.din_col_lower    <= bus.b_data;
                        r_last_grant         <= c_GRANT_B;
                    end else begin
                        bus.we_lower <= 1'b0;
                    end
                end

                ST_CLEAR: begin
                    // clr_start is deliberately ignored here: no restart.
                    bus.we_lower         <= 1'b1;
                    bus.wraddr_col_lower <= r_cnt;
                    bus.din_col_lower    <= CLR_VALUE;
                    r_cnt                <= r_cnt + ADDR_W'(1);
                    if (r_cnt == c_LAST_ADDR) begin
                        r_state      <= ST_ARB;
                        bus.clr_busy <= 1'b0;
                        bus.clr_done <= 1'b1;
                    end else begin
                        bus.clr_done <= 1'b0;
                    end
                end

                default: begin
                    r_state      <= ST_ARB;
                    bus.we_lower <= 1'b0;
                    bus.clr_busy <= 1'b0;
                    bus.clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pixel_wr_arbiter
//  Description : Directed self-checking bench for pixel_wr_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pixel_wr_arbiter;

    localparam int c_ADDR_W = 10;
    localparam int c_DATA_W = 32;
    localparam int c_DEPTH  = 1024;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    pixel_wr_arbiter_if #(.ADDR_W(c_ADDR_W), .DATA_W(c_DATA_W)) bus ();

    pixel_wr_arbiter #(
        .ADDR_W   (c_ADDR_W),
        .DATA_W   (c_DATA_W),
        .DEPTH    (c_DEPTH),
        .CLR_VALUE(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; registered outputs of that edge are stable after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] wv(input logic we, input logic done, input logic busy,
                                       input logic [9:0] addr, input logic [31:0] din);
        return {19'b0, we, done, busy, addr, din};
    endfunction

    function automatic logic [63:0] obs();
        return wv(bus.we_lower, bus.clr_done, bus.clr_busy, bus.wraddr_col_lower, bus.din_col_lower);
    endfunction

    // Full clear sweep after the start edge; optional second clr_start mid-way.
    task automatic run_sweep(input bit restart_mid);
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("clr_a_ready", {63'b0, bus.a_ready}, 64'd0);
            chk("clr_b_ready", {63'b0, bus.b_ready}, 64'd0);
            if (restart_mid && i == 500) bus.clr_start = 1'b1;
            step();
            bus.clr_start = 1'b0;
            chk("clr_word", obs(), wv(1'b1, i == c_DEPTH - 1, i != c_DEPTH - 1, i[9:0], 32'h0));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [9:0]  exp_addr [4];
    logic [31:0] exp_data [4];
    bit          exp_is_a [4];
    logic [9:0]  a_list   [2];
    logic [9:0]  b_list   [2];

    initial begin
        n_total = 0;
        n_bad   = 0;
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.clr_start = 1'b0;

        // Reset state
        do_reset();
        chk("rst_outputs", obs(), wv(1'b0, 1'b0, 1'b0, 10'h0, 32'h0));
        chk("rst_a_ready", {63'b0, bus.a_ready}, 64'd0);

        // Single A write, latency 1
        bus.a_valid = 1'b1; bus.a_addr = 10'h005; bus.a_data = 32'h4444_4444;
        #1;
        chk("single_a_ready", {62'b0, bus.a_ready, bus.b_ready}, 64'b10);
        step();
        bus.a_valid = 1'b0;
        chk("single_write", obs(), wv(1'b1, 1'b0, 1'b0, 10'h005, 32'h4444_4444));
        step();
        chk("single_idle", obs(), wv(1'b0, 1'b0, 1'b0, 10'h005, 32'h4444_4444));

        // Round-robin with both requesters valid, fresh after reset
        do_reset();
        a_list = '{10'd1, 10'd2};
        b_list = '{10'd100, 10'd101};
        exp_addr = '{10'd1, 10'd100, 10'd2, 10'd101};
        exp_is_a = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_data = '{32'hA000_0001, 32'hB000_0064, 32'hA000_0002, 32'hB000_0065};
        begin
            int ai;
            int bi;
            bit took_a;
            ai = 0;
            bi = 0;
            for (int i = 0; i < 4; i++) begin
                bus.a_valid = (ai < 2);
                bus.b_valid = (bi < 2);
                if (ai < 2) begin bus.a_addr = a_list[ai]; bus.a_data = 32'hA000_0000 | 32'(a_list[ai]); end
                if (bi < 2) begin bus.b_addr = b_list[bi]; bus.b_data = 32'hB000_0000 | 32'(b_list[bi]); end
                #1;
                chk("rr_ready", {62'b0, bus.a_ready, bus.b_ready}, {62'b0, exp_is_a[i], ~exp_is_a[i]});
                took_a = bus.a_ready;
                step();
                chk("rr_write", obs(), wv(1'b1, 1'b0, 1'b0, exp_addr[i], exp_data[i]));
                if (took_a) ai++;
                else bi++;
            end
            bus.a_valid = 1'b0;
            bus.b_valid = 1'b0;
            step();
            chk("rr_idle_we", {63'b0, bus.we_lower}, 64'd0);
        end

        // Plain clear sweep
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        chk("clr_start_state", obs(), wv(1'b0, 1'b0, 1'b1, 10'd101, 32'hB000_0065));
        run_sweep(1'b0);
        step();
        chk("clr_after", {61'b0, bus.we_lower, bus.clr_done, bus.clr_busy}, 64'd0);

        // A held across a clear, with a second clr_start mid-sweep
        bus.a_valid = 1'b1; bus.a_addr = 10'h3AA; bus.a_data = 32'h1234_5678;
        bus.clr_start = 1'b1;
        #1;
        chk("clrA_start_ready", {63'b0, bus.a_ready}, 64'd0);
        step();
        bus.clr_start = 1'b0;
        run_sweep(1'b1);
        chk("clrA_ready_after", {63'b0, bus.a_ready}, 64'd1);
        step();
        bus.a_valid = 1'b0;
        chk("clrA_write", obs(), wv(1'b1, 1'b0, 1'b0, 10'h3AA, 32'h1234_5678));

        // clr_start together with b_valid
        bus.b_valid = 1'b1; bus.b_addr = 10'h2BC; bus.b_data = 32'hCAFE_0001;
        bus.clr_start = 1'b1;
        #1;
        chk("clrB_start_ready", {63'b0, bus.b_ready}, 64'd0);
        step();
        bus.clr_start = 1'b0;
        run_sweep(1'b0);
        chk("clrB_ready_after", {63'b0, bus.b_ready}, 64'd1);
        step();
        bus.b_valid = 1'b0;
        chk("clrB_write", obs(), wv(1'b1, 1'b0, 1'b0, 10'h2BC, 32'hCAFE_0001));

        // Reset in the middle of a sweep (after address 300 is written)
        bus.clr_start = 1'b1;
        step();
        bus.clr_start = 1'b0;
        for (int i = 0; i <= 300; i++) begin
            step();
            chk("part_addr", {54'b0, bus.wraddr_col_lower}, 64'(i));
        end
        rst = 1'b0;
        step();
        chk("midrst_outputs", obs(), wv(1'b0, 1'b0, 1'b0, 10'h0, 32'h0));
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("midrst_no_write", obs(), wv(1'b0, 1'b0, 1'b0, 10'h0, 32'h0));
        end
        bus.a_valid = 1'b1; bus.a_addr = 10'h111; bus.a_data = 32'h0BAD_F00D;
        #1;
        chk("midrst_a_ready", {63'b0, bus.a_ready}, 64'd1);
        step();
        bus.a_valid = 1'b0;
        chk("midrst_a_write", obs(), wv(1'b1, 1'b0, 1'b0, 10'h111, 32'h0BAD_F00D));
        step();
        chk("midrst_a_idle", {63'b0, bus.we_lower}, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
